// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier: iterative shift-add N x M multiplier with runtime
// signed/unsigned mode. One adder, M iterations per product, start/busy/done
// handshake. Optional macro MULT_ACC_EN turns y into a multiply-accumulator
// and adds the acc_clr port.
module seq_signed_multiplier #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             k,
    input  logic [N-1:0]     a,
    input  logic [M-1:0]     b,
`ifdef MULT_ACC_EN
    input  logic             acc_clr,
`endif
    output logic             busy,
    output logic             done,
    output logic [N+M-1:0]   y
);

    localparam int CW = $clog2(M);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [N-1:0]     ra_q,    ra_d;
    logic [M-1:0]     rb_q,    rb_d;
    logic             rk_q,    rk_d;
    logic [N:0]       p_q,     p_d;
    logic [N+M-1:0]   y_q,     y_d;
    logic             done_q,  done_d;
`ifdef MULT_ACC_EN
    logic             clr_q,   clr_d;
`endif

    logic [N:0]       addend;
    logic [N+1:0]     sum;
    logic             last;
    logic             fill;
    logic [N:0]       p_next;
    logic [M-1:0]     rb_next;
    logic [N+M-1:0]   product;

    // One iteration of the datapath: conditional add/subtract, then shift right.
    // rb shifts right each iteration, so rb_q[0] is always the original b[cnt]
    // and the vacated top bits collect the low product bits.
    always_comb begin
        addend  = rk_q ? {ra_q[N-1], ra_q} : {1'b0, ra_q};
        last    = (cnt_q == CW'(M - 1));
        sum     = {1'b0, p_q};
        if (rb_q[0]) begin
            if (last && rk_q)
                sum = {1'b0, p_q} - {1'b0, addend};
            else
                sum = {1'b0, p_q} + {1'b0, addend};
        end
        fill    = rk_q ? sum[N] : sum[N+1];
        p_next  = {fill, sum[N:1]};
        rb_next = {sum[0], rb_q[M-1:1]};
        product = {p_next[N-1:0], rb_next};
    end

    // Next-state and register updates for the IDLE/RUN controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rk_d    = rk_q;
        p_d     = p_q;
        y_d     = y_q;
        done_d  = 1'b0;
`ifdef MULT_ACC_EN
        clr_d   = clr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    rk_d    = k;
`ifdef MULT_ACC_EN
                    clr_d   = acc_clr;
`endif
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                p_d   = p_next;
                rb_d  = rb_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
`ifdef MULT_ACC_EN
                    y_d = (clr_q ? '0 : y_q) + product;
`else
                    y_d = product;
`endif
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rk_q    <= 1'b0;
            p_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
`ifdef MULT_ACC_EN
            clr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rk_q    <= rk_d;
            p_q     <= p_d;
            y_q     <= y_d;
            done_q  <= done_d;
`ifdef MULT_ACC_EN
            clr_q   <= clr_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed testbench for seq_signed_multiplier at N=M=4.
module tb_seq_signed_multiplier;

    localparam int N = 4;
    localparam int M = 4;
    localparam int LIMIT = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           k = 1'b0;
    logic [N-1:0]   a = '0;
    logic [M-1:0]   b = '0;
`ifdef MULT_ACC_EN
    logic           acc_clr = 1'b1;
`endif
    logic           busy;
    logic           done;
    logic [N+M-1:0] y;

    int total = 0;
    int bad = 0;

    seq_signed_multiplier #(.N(N), .M(M)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .k      (k),
        .a      (a),
        .b      (b),
`ifdef MULT_ACC_EN
        .acc_clr(acc_clr),
`endif
        .busy   (busy),
        .done   (done),
        .y      (y)
    );

    always #5 clk = ~clk;

    // Present operands and hold start across exactly one rising edge.
    task automatic start_op(input logic kk, input logic [N-1:0] aa, input logic [M-1:0] bb);
        @(negedge clk);
        k = kk; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; lat counts edges after the accepting edge, bc counts busy cycles.
    task automatic wait_done(output int lat, output int bc);
        lat = 0; bc = 0;
        while (!done && lat < LIMIT) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h want=00", y); end
        rst = 1'b0;
    endtask

    task automatic test_signed_corner();
        int lat, bc;
        start_op(1'b1, 4'b1000, 4'b1000);
        wait_done(lat, bc);
        total++; if (y !== 8'h40) begin bad++; $display("FAIL corner_y got=%h want=40", y); end
        total++; if (lat !== 4) begin bad++; $display("FAIL corner_latency got=%0d want=4", lat); end
        total++; if (bc !== 4) begin bad++; $display("FAIL corner_busy_cycles got=%0d want=4", bc); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL corner_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_modes();
        int lat, bc;
        start_op(1'b1, 4'd7, 4'b1000);
        wait_done(lat, bc);
        total++; if (y !== 8'hC8) begin bad++; $display("FAIL signed_7xm8 got=%h want=c8", y); end
        total++; if (lat !== 4) begin bad++; $display("FAIL signed_latency got=%0d want=4", lat); end
        start_op(1'b0, 4'd7, 4'd8);
        wait_done(lat, bc);
        total++; if (y !== 8'h38) begin bad++; $display("FAIL unsigned_7x8 got=%h want=38", y); end
        start_op(1'b1, 4'b1111, 4'd7);
        wait_done(lat, bc);
        total++; if (y !== 8'hF9) begin bad++; $display("FAIL signed_m1x7 got=%h want=f9", y); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, gap;
        start_op(1'b0, 4'd15, 4'd15);
        wait_done(lat, bc);
        total++; if (y !== 8'hE1) begin bad++; $display("FAIL b2b_first got=%h want=e1", y); end
        // Still inside the done cycle: issue the next op.
        k = 1'b0; a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        gap = 1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
        while (!done && gap < LIMIT) begin
            @(posedge clk); #1;
            gap++;
        end
        total++; if (gap !== 5) begin bad++; $display("FAIL b2b_gap got=%0d want=5", gap); end
        total++; if (y !== 8'h0F) begin bad++; $display("FAIL b2b_second got=%h want=0f", y); end
    endtask

    task automatic test_ignore_start();
        int lat, bc, extra;
        start_op(1'b0, 4'd2, 4'd3);
        @(posedge clk); #1;
        k = 1'b1; a = 4'd9; b = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        total++; if (y !== 8'h06) begin bad++; $display("FAIL ignore_y got=%h want=06", y); end
        total++; if (lat !== 2) begin bad++; $display("FAIL ignore_latency got=%0d want=2", lat); end
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ignore_no_second got=%0d want=0", extra); end
        total++; if (y !== 8'h06) begin bad++; $display("FAIL ignore_y_held got=%h want=06", y); end
    endtask

    task automatic test_abort();
        int lat, bc, extra;
        start_op(1'b0, 4'd5, 4'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
        total++; if (y !== 8'h00) begin bad++; $display("FAIL abort_y got=%h want=00", y); end
        @(posedge clk); #1;
        rst = 1'b0;
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", extra); end
        start_op(1'b1, 4'b1111, 4'b1111);
        wait_done(lat, bc);
        total++; if (y !== 8'h01) begin bad++; $display("FAIL abort_then_m1xm1 got=%h want=01", y); end
    endtask

`ifdef MULT_ACC_EN
    task automatic test_acc();
        int lat, bc;
        acc_clr = 1'b1;
        start_op(1'b1, 4'd7, 4'b1000);
        wait_done(lat, bc);
        total++; if (y !== 8'hC8) begin bad++; $display("FAIL acc_signed_clr got=%h want=c8", y); end
        acc_clr = 1'b0;
        start_op(1'b1, 4'b1000, 4'b1000);
        wait_done(lat, bc);
        total++; if (y !== 8'h08) begin bad++; $display("FAIL acc_signed_add got=%h want=08", y); end
        acc_clr = 1'b1;
        start_op(1'b0, 4'd15, 4'd15);
        wait_done(lat, bc);
        total++; if (y !== 8'hE1) begin bad++; $display("FAIL acc_unsigned_clr got=%h want=e1", y); end
        acc_clr = 1'b0;
        start_op(1'b0, 4'd15, 4'd15);
        wait_done(lat, bc);
        total++; if (y !== 8'hC2) begin bad++; $display("FAIL acc_unsigned_wrap got=%h want=c2", y); end
        acc_clr = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_signed_corner();
        test_modes();
        test_back_to_back();
        test_ignore_start();
        test_abort();
`ifdef MULT_ACC_EN
        test_acc();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_signed_multiplier.md
# seq_signed_multiplier

Iterative shift-add multiplier for N-bit by M-bit operands with a runtime signed/unsigned mode select. It produces a full-width N+M-bit product over M cycles using one adder. It sits beside the combinational array multipliers and is the area-optimised choice for datapaths that can tolerate multi-cycle latency. A start/busy/done handshake lets a controller issue back-to-back operations.

## Interface
- N, 8, width of multiplicand a (N ≥ 2)
- M, 8, width of multiplier b (M ≥ 2)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- k  input  1  mode: 1 = both operands two's complement, 0 = both unsigned; sampled with start
- a  input  N  multiplicand; sampled with start
- b  input  M  multiplier; sampled with start
- acc_clr  input  1  present only with MULT_ACC_EN; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when y is updated
- y  output  N+M  product (or accumulation); held until the next done

## Operation
- States: IDLE, RUN.
- Counter: cnt, clog2(M) bits.
- Registers: operand registers ra, rb, rk; partial register P, N+1 bits; y register.
- IDLE, start=1 at an edge:
  - latch a, b, k into ra, rb, rk
  - clear P and cnt
  - go to RUN, set busy=1
- IDLE, start=0: stay in IDLE.
- RUN, one iteration per edge, examining rb[cnt]:
  - Addend = ra extended to N+1 bits: sign-extended if rk=1, zero-extended if rk=0.
  - If rb[cnt]=1 and cnt<M-1: P ← P + addend.
  - If rb[cnt]=1, cnt=M-1, rk=1: P ← P − addend (the MSB of b carries negative weight).
  - If rb[cnt]=1, cnt=M-1, rk=0: P ← P + addend.
  - If rb[cnt]=0: P unchanged.
  - After the add, arithmetically shift {P, low-product bits} right by one. Shift in P's sign if rk=1, or the carry-out if rk=0.
  - Low-product bits are collected in rb's vacated positions.
- On the edge where cnt=M-1 completes:
  - load y with the N+M-bit result
  - pulse done
  - drop busy
  - return to IDLE
- Arithmetic is exact for all operand pairs in both modes. The signed product of (−2^(N−1)) × (−2^(M−1)) = 2^(N+M−2) fits without overflow.
- start while busy=1 is ignored and has no effect on the operation in flight.
- Operand inputs may change freely after the accepting edge.
- Mode mixing (one signed and one unsigned operand) is not supported.

## Timing
- Reset values:
  - busy=0, done=0, y=0
  - state IDLE, P=0, cnt=0
- Latency: start accepted at edge E0; iterations at E1…EM. After EM, y is valid and done=1 for exactly one cycle, and busy=0.
- busy is high from after E0 through after EM−1.
- Back-to-back: start may be high during the done cycle. It is accepted at EM+1, giving a throughput of one result per M+1 cycles.
- rst asserted mid-operation immediately aborts:
  - outputs return to their reset values
  - no done pulse is produced for the aborted operation
- rst deasserted synchronously to clk by the system.
- done and y change only on clk edges; y is stable between done pulses.

## Configuration
- Macro MULT_ACC_EN, defined: multiply-accumulate mode.
  - The acc_clr port is present.
  - At completion, y ← (acc_clr_latched ? 0 : y) + product, modulo 2^(N+M).
  - The accumulation is signed or unsigned per the latched k; wrap-around is silent.
  - acc_clr is latched with start.
- Macro MULT_ACC_EN, undefined:
  - the acc_clr port is absent
  - at completion, y ← product
- Latency and handshake are identical in both builds.

## Test plan
- N=M=4, k=1, a=4'b1000, b=4'b1000 → done after 4 cycles, y=8'h40 (+64); busy high exactly 4 cycles.
- N=M=4, k=1, a=7, b=−8 → y=8'hC8 (−56). Same operands with k=0 (7×8) → y=8'h38.
- N=M=4, k=0, a=15, b=15 → y=8'hE1. Immediately re-issue start during the done cycle with a=3, b=5 → second done 5 cycles after the first, y=8'h0F.
- Pulse start with a=9, b=9 two cycles into a running op (a=2, b=3, k=0) → the in-flight op completes with y=8'h06; the second start is not executed.
- Assert rst at cycle 2 of an op → busy=0, done=0, y=0 at once; no done pulse follows. Release rst, then issue a=−1, b=−1, k=1 → y=8'h01.
- MULT_ACC_EN builds:
  - k=1 ops: −56 with acc_clr=1, then +64 with acc_clr=0 → y=8'hC8, then 8'h08.
  - k=0 ops: 225 with acc_clr=1, then 225 with acc_clr=0 → y=8'hE1, then 8'hC2 (wrap).
